result_checker: RTL and testbench

RESULT_CHECKER -- requirements
Module: result_checker

---
 rtl/platform_pkg.sv | 19 +
 rtl/pattern_lfsr.sv | 31 +++
 rtl/result_checker.sv | 192 +++++++++++++++++++
 tb/tb_result_checker.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/platform_pkg.sv
// Shared platform definitions: checker FSM encoding and the test-pattern LFSR
// (x^8+x^6+x^5+x^4+1) used by both the pattern writer and the result checker.
package platform_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } chk_state_e;

    // Feedback taps for x^8+x^6+x^5+x^4+1 in a left-shifting Fibonacci LFSR.
    localparam logic [7:0] LFSR_TAPS         = 8'hB8;
    localparam logic [7:0] LFSR_DEFAULT_SEED = 8'hA5;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pattern_lfsr.sv
// 8-bit expected-pattern generator: synchronous load of SEED, one step per advance.
module pattern_lfsr
    import platform_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_adv,
    output logic [7:0] o_value
);

    logic [7:0] r_value;

    // Pattern state register; load wins over advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= SEED;
        end else if (i_load) begin
            r_value <= SEED;
        end else if (i_adv) begin
            r_value <= lfsr_next(r_value);
        end else begin
            r_value <= r_value;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/result_checker.sv
// Memory read-back checker: compares DEPTH read beats against the LFSR pattern.
// Optional CHK_FIRST_ERR_EN captures the address of the first mismatch per pass.
module result_checker
    import platform_pkg::*;
#(
    parameter int         ADDR_W    = 10,
    parameter int         DATA_W    = 8,
    parameter int         DEPTH     = 1024,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              read_enable,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err_flag,
    output logic [7:0]        led,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] CNT_SAT   = (ADDR_W+1)'(127);

    function automatic logic [6:0] sat7(input logic [ADDR_W:0] c);
        if (c > CNT_SAT) begin
            return 7'h7F;
        end else begin
            return c[6:0];
        end
    endfunction

    chk_state_e        r_state;
    logic              r_re_d;
    logic [ADDR_W:0]   r_beat_cnt;
    logic [ADDR_W:0]   r_err_cnt;
    logic              r_cmp_valid;
    logic              r_cmp_err;
    logic              r_done;
    logic              r_err_flag;
    logic [7:0]        r_led;

    logic              w_rise;
    logic              w_beat;
    logic              w_load;
    logic              w_last;
    logic [7:0]        w_lfsr;
    logic [DATA_W-1:0] w_expect;
    logic [ADDR_W:0]   w_beat_cnt_nxt;
    logic [ADDR_W:0]   w_err_cnt_nxt;
    logic              w_err_flag_nxt;

    pattern_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (sys_clk),
        .rst_n   (sys_rst),
        .i_load  (w_load),
        .i_adv   (w_beat),
        .o_value (w_lfsr)
    );

    // Beat qualification and next-value terms for counters and flags.
    always_comb begin
        w_rise   = read_enable & ~r_re_d;
        w_load   = (r_state == ST_IDLE) && w_rise;
        w_beat   = (r_state == ST_CHECK) && read_enable && rd_valid && (r_beat_cnt != CNT_DEPTH);
        w_last   = r_cmp_valid && (r_beat_cnt == CNT_DEPTH);
        w_expect = DATA_W'(w_lfsr);
        w_beat_cnt_nxt = r_beat_cnt;
        w_err_cnt_nxt  = r_err_cnt;
        w_err_flag_nxt = r_err_flag;
        if (w_beat) begin
            w_beat_cnt_nxt = r_beat_cnt + CNT_ONE;
        end else begin
            w_beat_cnt_nxt = r_beat_cnt;
        end
        if (r_cmp_valid && r_cmp_err) begin
            w_err_cnt_nxt  = r_err_cnt + CNT_ONE;
            w_err_flag_nxt = 1'b1;
        end else begin
            w_err_cnt_nxt  = r_err_cnt;
            w_err_flag_nxt = r_err_flag;
        end
    end

    // Main FSM with registered status outputs.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state     <= ST_IDLE;
            r_re_d      <= 1'b1;   // a level held through reset is not a new edge
            r_beat_cnt  <= '0;
            r_err_cnt   <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_err   <= 1'b0;
            r_done      <= 1'b0;
            r_err_flag  <= 1'b0;
            r_led       <= 8'h00;
        end else begin
            r_re_d      <= read_enable;
            r_cmp_valid <= w_beat;
            r_cmp_err   <= w_beat && (rd_data != w_expect);
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    r_led  <= 8'h00;
                    if (w_rise) begin
                        r_state    <= ST_CHECK;
                        r_beat_cnt <= '0;
                        r_err_cnt  <= '0;
                        r_err_flag <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (!read_enable) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                        r_led   <= 8'h00;
                    end else if (w_last) begin
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_err_cnt  <= w_err_cnt_nxt;
                        r_err_flag <= w_err_flag_nxt;
                        r_led      <= {~w_err_flag_nxt, sat7(w_err_cnt_nxt)};
                    end else begin
                        r_state    <= ST_CHECK;
                        r_done     <= 1'b0;
                        r_beat_cnt <= w_beat_cnt_nxt;
                        r_err_cnt  <= w_err_cnt_nxt;
                        r_err_flag <= w_err_flag_nxt;
                        r_led      <= {1'b0, w_beat_cnt_nxt[ADDR_W-1 -: 7]};
                    end
                end
                ST_DONE: begin
                    if (!read_enable) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                        r_led   <= 8'h00;
                    end else begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_led   <= r_led;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_led   <= 8'h00;
                end
            endcase
        end
    end

    assign done     = r_done;
    assign err_flag = r_err_flag;
    assign led      = r_led;

`ifdef CHK_FIRST_ERR_EN
    logic [ADDR_W-1:0] r_cmp_addr;
    logic [ADDR_W-1:0] r_first_err_addr;

    // First-mismatch address capture, aligned with the registered compare.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_cmp_addr       <= '0;
            r_first_err_addr <= '0;
        end else begin
            if (w_beat) begin
                r_cmp_addr <= rd_addr;
            end else begin
                r_cmp_addr <= r_cmp_addr;
            end
            if (w_load) begin
                r_first_err_addr <= '0;
            end else if ((r_state == ST_CHECK) && read_enable && r_cmp_valid && r_cmp_err && !r_err_flag) begin
                r_first_err_addr <= r_cmp_addr;
            end else begin
                r_first_err_addr <= r_first_err_addr;
            end
        end
    end

    assign first_err_addr = r_first_err_addr;
`else
    logic w_unused_addr;
    assign w_unused_addr  = ^rd_addr;
    assign first_err_addr = '0;
`endif

endmodule

// File: tb/tb_result_checker.sv
// Self-checking bench for result_checker: directed pass table, corner sequences
// and randomized passes against a pattern/error-count reference model.
module tb_result_checker;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1024;
`ifdef CHK_FIRST_ERR_EN
    localparam bit FE_EN = 1'b1;
`else
    localparam bit FE_EN = 1'b0;
`endif

    logic              sys_clk;
    logic              sys_rst;
    logic              read_enable;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              done;
    logic              err_flag;
    logic [7:0]        led;
    logic [ADDR_W-1:0] first_err_addr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] pat [DEPTH];
    bit         err_mask [DEPTH];

    typedef struct {
        string      name;
        int         err_a;
        int         err_b;
        bit         all_wrong;
        bit         gaps;
        logic [7:0] exp_led;
        logic       exp_flag;
        int         exp_first;
    } vec_t;

    vec_t vecs [4];

    result_checker #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LFSR_SEED(8'hA5)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .read_enable    (read_enable),
        .rd_valid       (rd_valid),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .done           (done),
        .err_flag       (err_flag),
        .led            (led),
        .first_err_addr (first_err_addr)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start_pass();
        read_enable = 1'b0;
        tick();
        read_enable = 1'b1;
        tick();
    endtask

    // Feed beats [from, to) using err_mask to decide which beats carry bad data.
    task automatic feed(input int from, input int to, input bit gaps);
        for (int i = from; i < to; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    rd_valid = 1'b0;
                    rd_data  = 8'($urandom);
                    tick();
                end
            end
            rd_valid = 1'b1;
            rd_addr  = ADDR_W'(i);
            rd_data  = err_mask[i] ? (pat[i] ^ 8'(1 << $urandom_range(0, 7))) : pat[i];
            tick();
        end
        rd_valid = 1'b0;
    endtask

    // Reference result for a complete pass, computed from err_mask.
    task automatic check_done(input string tag);
        int nerr;
        int first;
        logic [7:0] exp_led;
        nerr  = 0;
        first = 0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (err_mask[i]) begin
                nerr++;
                first = i;
            end
        end
        exp_led = {(nerr == 0) ? 1'b1 : 1'b0, (nerr > 127) ? 7'h7F : 7'(nerr)};
        chk({tag, "_done_early"}, 32'(done), 32'd0);
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_flag"}, 32'(err_flag), (nerr != 0) ? 32'd1 : 32'd0);
        chk({tag, "_led"}, 32'(led), 32'(exp_led));
        chk({tag, "_first"}, 32'(first_err_addr), FE_EN ? 32'(first) : 32'd0);
    endtask

    task automatic end_pass(input string tag);
        read_enable = 1'b0;
        tick();
        chk({tag, "_idle_done"}, 32'(done), 32'd0);
        chk({tag, "_idle_led"}, 32'(led), 32'h00);
    endtask

    task automatic clear_mask();
        for (int i = 0; i < DEPTH; i++) err_mask[i] = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        v = 8'hA5;
        for (int i = 0; i < DEPTH; i++) begin
            pat[i] = v;
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        end

        vecs[0] = '{"clean",    -1,   -1, 1'b0, 1'b0, 8'h80, 1'b0, 0};
        vecs[1] = '{"two_err",   5,  700, 1'b0, 1'b1, 8'h02, 1'b1, 5};
        vecs[2] = '{"all_wrong",-1,   -1, 1'b1, 1'b0, 8'h7F, 1'b1, 0};
        vecs[3] = '{"last_err", 1023, -1, 1'b0, 1'b1, 8'h01, 1'b1, 1023};

        sys_rst     = 1'b0;
        read_enable = 1'b0;
        rd_valid    = 1'b0;
        rd_addr     = '0;
        rd_data     = '0;
        repeat (3) tick();
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flag", 32'(err_flag), 32'd0);
        chk("rst_led", 32'(led), 32'h00);
        chk("rst_first", 32'(first_err_addr), 32'd0);
        sys_rst = 1'b1;
        tick();

        // Directed passes from the table.
        for (int k = 0; k < 4; k++) begin
            clear_mask();
            for (int i = 0; i < DEPTH; i++) err_mask[i] = vecs[k].all_wrong;
            if (vecs[k].err_a >= 0) err_mask[vecs[k].err_a] = 1'b1;
            if (vecs[k].err_b >= 0) err_mask[vecs[k].err_b] = 1'b1;
            start_pass();
            feed(0, DEPTH, vecs[k].gaps);
            chk({vecs[k].name, "_pre"}, 32'(done), 32'd0);
            tick();
            chk({vecs[k].name, "_done"}, 32'(done), 32'd1);
            chk({vecs[k].name, "_led"}, 32'(led), 32'(vecs[k].exp_led));
            chk({vecs[k].name, "_flag"}, 32'(err_flag), 32'(vecs[k].exp_flag));
            chk({vecs[k].name, "_first"}, 32'(first_err_addr), FE_EN ? 32'(vecs[k].exp_first) : 32'd0);
            end_pass(vecs[k].name);
        end

        // rd_valid ignored in DONE and IDLE.
        clear_mask();
        err_mask[5] = 1'b1;
        err_mask[700] = 1'b1;
        start_pass();
        feed(0, DEPTH, 1'b0);
        check_done("ign");
        for (int i = 0; i < 5; i++) begin
            rd_valid = 1'b1;
            rd_data  = 8'($urandom);
            tick();
            chk("ign_done_led", 32'(led), 32'h02);
            chk("ign_done_done", 32'(done), 32'd1);
        end
        rd_valid = 1'b0;
        end_pass("ign");
        for (int i = 0; i < 5; i++) begin
            rd_valid = 1'b1;
            rd_data  = 8'($urandom);
            tick();
            chk("ign_idle_led", 32'(led), 32'h00);
        end
        rd_valid = 1'b0;
        clear_mask();
        start_pass();
        feed(0, DEPTH, 1'b0);
        check_done("ign_after");
        end_pass("ign_after");

        // Abort after 300 beats, then restart from seed.
        clear_mask();
        err_mask[17] = 1'b1;
        start_pass();
        feed(0, 300, 1'b0);
        chk("abort_led_cnt", 32'(led), 32'h25);
        read_enable = 1'b0;
        tick();
        chk("abort_led", 32'(led), 32'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_done", 32'(done), 32'd0);
        end
        clear_mask();
        start_pass();
        feed(0, DEPTH, 1'b1);
        check_done("restart");
        end_pass("restart");

        // Asynchronous reset mid-pass; a held read_enable must not restart.
        clear_mask();
        err_mask[10] = 1'b1;
        start_pass();
        feed(0, 100, 1'b0);
        chk("pre_rst_flag", 32'(err_flag), 32'd1);
        @(posedge sys_clk);
        #3 sys_rst = 1'b0;
        #1;
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_flag", 32'(err_flag), 32'd0);
        chk("arst_led", 32'(led), 32'h00);
        chk("arst_first", 32'(first_err_addr), 32'd0);
        #7 sys_rst = 1'b1;
        tick();
        clear_mask();
        for (int i = 0; i < 40; i++) err_mask[i] = 1'b1;
        feed(0, 40, 1'b0);
        tick();
        chk("norestart_led", 32'(led), 32'h00);
        chk("norestart_flag", 32'(err_flag), 32'd0);
        chk("norestart_done", 32'(done), 32'd0);
        clear_mask();
        start_pass();
        feed(0, DEPTH, 1'b0);
        check_done("post_rst");
        end_pass("post_rst");

        // Randomized passes against the model.
        for (int r = 0; r < 4; r++) begin
            int nerr_req;
            clear_mask();
            nerr_req = (r == 3) ? 200 : $urandom_range(0, 60);
            for (int e = 0; e < nerr_req; e++) err_mask[$urandom_range(0, DEPTH - 1)] = 1'b1;
            start_pass();
            feed(0, DEPTH, 1'b1);
            check_done("rand");
            end_pass("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
